// File: rtl/vram_dma.sv
// vram_dma: register-programmed copy/fill engine streaming bytes into the GPU write port
module vram_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_B,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              vblank,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              dst_we,
    output logic [DATA_W-1:0] dst_data,
    output logic              busy,
    output logic              done_irq_B
);
    typedef enum logic [2:0] {IDLE, WAIT_VB, READ, WRITE, DONE} state_t;
    state_t state, nxt;
    logic [2*DATA_W-1:0] src_r, dst_r;
    logic [LEN_W-1:0] len_r;
    logic [DATA_W-1:0] fill_r;
    logic mode, wait_vb, irq_en, done, irq;
    logic [ADDR_W-1:0] cur_src, cur_dst;
    logic [LEN_W:0] rem;
    logic wr_ctrl, start, abort, clr;
    assign busy     = (state == WAIT_VB) || (state == READ) || (state == WRITE);
    assign wr_ctrl  = cfg_we && (cfg_addr == 3'd5);
    assign start    = wr_ctrl && cfg_wdata[0] && !cfg_wdata[4] && !busy;
    assign abort    = wr_ctrl && cfg_wdata[4] && busy;
    assign clr      = cfg_we && (cfg_addr == 3'd7) && cfg_wdata[1];
    assign src_rd   = state == READ;
    assign dst_we   = state == WRITE;
    assign src_addr = cur_src;
    assign dst_addr = cur_dst;
    assign dst_data = dst_we ? (mode ? fill_r : src_data) : '0;
    assign done_irq_B = ~irq;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = !start ? IDLE : cfg_wdata[2] ? WAIT_VB : cfg_wdata[1] ? WRITE : READ;
            WAIT_VB:    nxt = !vblank ? WAIT_VB : mode ? WRITE : READ;
            READ:       nxt = WRITE;
            WRITE:      nxt = (rem == (LEN_W+1)'(1)) ? DONE : (wait_vb && !vblank) ? WAIT_VB : mode ? WRITE : READ;
            default:    nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_B)
        if (!rst_B) state <= IDLE;
        else        state <= nxt;
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            fill_r  <= '0;
            mode    <= 1'b0;
            wait_vb <= 1'b0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            irq     <= 1'b0;
            cur_src <= '0;
            cur_dst <= '0;
            rem     <= '0;
        end else begin
            if (cfg_we && !busy)
                case (cfg_addr)
                    3'd0:    src_r[DATA_W-1:0]        <= cfg_wdata;
                    3'd1:    src_r[2*DATA_W-1:DATA_W] <= cfg_wdata;
                    3'd2:    dst_r[DATA_W-1:0]        <= cfg_wdata;
                    3'd3:    dst_r[2*DATA_W-1:DATA_W] <= cfg_wdata;
                    3'd4:    len_r                    <= cfg_wdata[LEN_W-1:0];
                    3'd5:    {irq_en, wait_vb, mode}  <= cfg_wdata[3:1];
                    3'd6:    fill_r                   <= cfg_wdata;
                    default: ;
                endcase
            if (start) begin
                cur_src <= src_r[ADDR_W-1:0];
                cur_dst <= dst_r[ADDR_W-1:0];
                rem     <= {len_r == '0, len_r};
                done    <= 1'b0;
                irq     <= 1'b0;
            end else if (state == WRITE) begin
                cur_dst <= cur_dst + ADDR_W'(1);
                cur_src <= mode ? cur_src : cur_src + ADDR_W'(1);
                rem     <= rem - (LEN_W+1)'(1);
            end
            if (clr) begin
                done <= 1'b0;
                irq  <= 1'b0;
            end
            if (nxt == DONE) begin
                done <= 1'b1;
                irq  <= irq_en;
            end
        end
    end
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            3'd0:    cfg_rdata = src_r[DATA_W-1:0];
            3'd1:    cfg_rdata = src_r[2*DATA_W-1:DATA_W];
            3'd2:    cfg_rdata = dst_r[DATA_W-1:0];
            3'd3:    cfg_rdata = dst_r[2*DATA_W-1:DATA_W];
            3'd4:    cfg_rdata = DATA_W'(len_r);
            3'd5:    cfg_rdata = DATA_W'({irq_en, wait_vb, mode, 1'b0});
            3'd6:    cfg_rdata = fill_r;
            default: cfg_rdata = DATA_W'({done, busy});
        endcase
    end
endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: directed/randomized checks of vram_dma against a transfer-list reference model
module tb_vram_dma;
    logic clk = 0, rst_B = 0, cfg_we = 0, vblank = 0;
    logic [2:0] cfg_addr = 0;
    logic [7:0] cfg_wdata = 0, cfg_rdata, src_data = 0, dst_data;
    logic [15:0] src_addr, dst_addr;
    logic src_rd, dst_we, busy, done_irq_B;
    int tests = 0, fails = 0, cyc = 0, first_s = -1, last_s = -1, overlap = 0, gate_bad = 0;
    int sc, n, nw;
    bit gate_on = 0;
    logic [1:0] vb_hist = 2'b11;
    logic [7:0] mem [0:65535];
    logic [23:0] wq[$], eq[$];
    logic [15:0] rq[$], er[$];

    vram_dma dut (
        .clk(clk), .rst_B(rst_B), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .vblank(vblank), .src_addr(src_addr), .src_rd(src_rd),
        .src_data(src_data), .dst_addr(dst_addr), .dst_we(dst_we), .dst_data(dst_data),
        .busy(busy), .done_irq_B(done_irq_B)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) vb_hist <= {vb_hist[0], vblank};
    // source memory: one-cycle read latency
    always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

    always @(negedge clk) begin
        if (dst_we) wq.push_back({dst_addr, dst_data});
        if (src_rd) rq.push_back(src_addr);
        if (src_rd || dst_we) begin
            if (first_s < 0) first_s <= cyc;
            last_s <= cyc;
            // a strobe needs vblank high at one of the two preceding decision edges
            if (gate_on && vb_hist == 2'b00) gate_bad <= gate_bad + 1;
        end
        if (src_rd && dst_we) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_addr = a;
        cfg_wdata = d;
        cfg_we = 1;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [7:0] len, input logic [7:0] fv);
        cfg_write(0, s[7:0]);
        cfg_write(1, s[15:8]);
        cfg_write(2, d[7:0]);
        cfg_write(3, d[15:8]);
        cfg_write(4, len);
        cfg_write(6, fv);
    endtask

    task automatic go(input logic [7:0] ctrl);
        wq.delete(); rq.delete(); eq.delete(); er.delete();
        first_s = -1;
        last_s = -1;
        cfg_write(5, ctrl);
        sc = cyc;
    endtask

    // reference: byte i goes from src+i (copy) to dst+i, addresses modulo 2^16
    task automatic model(input logic [15:0] s, input logic [15:0] d, input int cnt, input bit fill, input logic [7:0] fv);
        logic [15:0] sa, da;
        for (int i = 0; i < cnt; i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
            eq.push_back({da, fill ? fv : mem[sa]});
            if (!fill) er.push_back(sa);
        end
    endtask

    task automatic cmp_xfer(input string tag);
        chk($sformatf("%s_nwr", tag), wq.size(), eq.size());
        chk($sformatf("%s_nrd", tag), rq.size(), er.size());
        for (int i = 0; i < eq.size() && i < wq.size(); i++) chk($sformatf("%s_w%0d", tag, i), wq[i], eq[i]);
        for (int i = 0; i < er.size() && i < rq.size(); i++) chk($sformatf("%s_r%0d", tag, i), rq[i], er[i]);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
        chk($sformatf("%s_timeout", tag), busy, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_ctl", {busy, src_rd, dst_we, done_irq_B}, 4'b0001);
        chk("rst_bus", {src_addr, dst_addr, dst_data}, 0);
        rd_chk("rst_status", 7, 8'h00);
        rst_B = 1;
        @(negedge clk);

        // 1: basic copy
        mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h22; mem[16'h0202] = 8'h33; mem[16'h0203] = 8'h44;
        prog(16'h0200, 16'h3f00, 8'd4, 8'h00);
        go(8'h01);
        wait_idle("t1", 50);
        model(16'h0200, 16'h3f00, 4, 0, 8'h00);
        cmp_xfer("t1");
        chk("t1_first", first_s, sc);
        chk("t1_last", last_s, sc + 7);
        chk("t1_irq", done_irq_B, 1);
        rd_chk("t1_status", 7, 8'h02);

        // 2: fill 256 bytes with irq
        prog(16'h0000, 16'h3900, 8'd0, 8'hA5);
        go(8'h0B);
        wait_idle("t2", 400);
        model(16'h0000, 16'h3900, 256, 1, 8'hA5);
        cmp_xfer("t2");
        chk("t2_first", first_s, sc);
        chk("t2_last", last_s, sc + 255);
        chk("t2_irq_low", done_irq_B, 0);
        rd_chk("t2_status", 7, 8'h02);
        @(negedge clk);
        cfg_write(7, 8'h02);
        chk("t2_irq_clr", done_irq_B, 1);
        rd_chk("t2_status_clr", 7, 8'h00);
        @(negedge clk);

        // 3: vblank gated copy
        n = int'($urandom_range(0, 65535));
        prog(16'(n), 16'h4000, 8'd6, 8'h00);
        vblank = 1;
        gate_on = 1;
        go(8'h05);
        repeat (6) @(negedge clk);
        vblank = 0;
        repeat (20) @(negedge clk);
        vblank = 1;
        #1;
        chk("t3_paused", wq.size() < 6, 1);
        wait_idle("t3", 100);
        gate_on = 0;
        model(16'(n), 16'h4000, 6, 0, 8'h00);
        cmp_xfer("t3");
        chk("t3_gate", gate_bad, 0);
        chk("t3_irq", done_irq_B, 1);

        // 4: address wrap
        prog(16'hFFFE, 16'hFFFF, 8'd3, 8'h00);
        go(8'h01);
        wait_idle("t4", 50);
        model(16'hFFFE, 16'hFFFF, 3, 0, 8'h00);
        cmp_xfer("t4");

        // 5a: abort after 10 writes
        prog(16'h0000, 16'h2000, 8'd100, 8'h5A);
        go(8'h03);
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            if (dst_we) n++;
            if (n < 10) @(negedge clk);
        end
        cfg_write(5, 8'h10);
        repeat (3) @(negedge clk);
        model(16'h0000, 16'h2000, 10, 1, 8'h5A);
        cmp_xfer("t5a");
        chk("t5a_busy", busy, 0);
        rd_chk("t5a_status", 7, 8'h00);
        @(negedge clk);

        // 5b: asynchronous reset mid-transfer
        prog(16'h0000, 16'h2100, 8'd100, 8'h3C);
        go(8'h03);
        repeat (5) @(negedge clk);
        #2;
        rst_B = 0;
        cfg_addr = 4;
        #1;
        chk("t5b_ctl", {busy, src_rd, dst_we, done_irq_B}, 4'b0001);
        chk("t5b_bus", {src_addr, dst_addr, dst_data}, 0);
        chk("t5b_len", cfg_rdata, 0);
        nw = wq.size();
        repeat (3) @(negedge clk);
        chk("t5b_quiet", wq.size(), nw);
        rst_B = 1;
        @(negedge clk);

        // 6: register and start writes while busy are ignored
        n = int'($urandom_range(0, 65535));
        prog(16'(n), 16'h5678, 8'd5, 8'h99);
        go(8'h01);
        @(negedge clk);
        cfg_write(2, 8'h77);
        cfg_write(5, 8'h03);
        wait_idle("t6", 50);
        model(16'(n), 16'h5678, 5, 0, 8'h00);
        cmp_xfer("t6");
        rd_chk("t6_dst_lo", 2, 8'h78);
        rd_chk("t6_ctrl", 5, 8'h00);
        chk("overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
